// File: rtl/cnn_layer_accel_fas_vec_add_ctrl.sv
// FAS vector-add scheduler: sequences source FIFO pops, pipe_enable and add selects.
// Optional stall performance counter built when VEC_ADD_CTRL_PERF_CNT_EN is defined.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start
//   ST_FILL  | pre-1x1 flow: pop sources once per pixel, build sum array
//   ST_REUSE | pre-1x1 flow: replay stored sums for remaining 1x1 kernels
//   ST_POST  | post-1x1 flow: pop sources on every kernel pass
//   ST_DONE  | one-cycle completion
module cnn_layer_accel_fas_vec_add_ctrl #(
    parameter int DPTH_WTH = 16,
    parameter int KRNL_WTH = 16,
    parameter int PIX_WTH  = 20
) (
    input  logic                clk_FAS,
    input  logic                rst,
    input  logic                FAS_rdy_n,
    input  logic                start,
    input  logic [2:0]          cfg_mode,
    input  logic [DPTH_WTH-1:0] krnl1x1_dpth_end_cfg,
    input  logic [KRNL_WTH-1:0] num_krnl1x1_cfg,
    input  logic [PIX_WTH-1:0]  num_pix_cfg,
    input  logic                convMap_fifo_empty,
    input  logic                partMap_fifo_empty,
    input  logic                resdMap_fifo_empty,
    input  logic                prevMap_fifo_empty,
    input  logic                conv1x1_dwc_fifo_empty,
    input  logic                sum_rdy,
    output logic                convMap_fifo_rd_en,
    output logic                partMap_fifo_rd_en,
    output logic                resdMap_fifo_rd_en,
    output logic                prevMap_fifo_rd_en,
    output logic                conv1x1_dwc_fifo_rd_en,
    output logic                vector_add_pm,
    output logic                vector_add_rm0,
    output logic                vector_add_rm1,
    output logic                vector_add_rm_conv,
    output logic                vector_add_pv,
    output logic                pipe_enable,
    output logic                busy,
    output logic                process_cmpl,
    output logic                cfg_err,
    output logic [31:0]         stall_cycles
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_REUSE = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] MD_NONE    = 3'd0;
    localparam logic [2:0] MD_PM      = 3'd1;
    localparam logic [2:0] MD_RM0     = 3'd2;
    localparam logic [2:0] MD_PM_RM1  = 3'd3;
    localparam logic [2:0] MD_RM_CONV = 3'd4;
    localparam logic [2:0] MD_PV      = 3'd5;

    state_t              r_state;
    logic [2:0]          r_mode;
    logic [DPTH_WTH-1:0] r_dpth_end;
    logic [KRNL_WTH-1:0] r_num_krnl;
    logic [PIX_WTH-1:0]  r_num_pix;
    logic [DPTH_WTH-1:0] r_dpth;
    logic [KRNL_WTH-1:0] r_krnl;
    logic [PIX_WTH-1:0]  r_pix;
    logic                r_cfg_err;

    logic                w_need_conv;
    logic                w_need_part;
    logic                w_need_resd;
    logic                w_need_prev;
    logic                w_need_dwc;
    logic                w_srcs_rdy;
    logic                w_path_rdy;
    logic                w_pop_state;
    logic                w_fire;
    logic                w_adv;
    logic                w_pass_end;
    logic                w_last_pass;
    logic                w_pix_last;
    logic                w_pre_flow;
    logic                w_start_ok;
    logic [KRNL_WTH-1:0] w_krnl_nxt;
    logic [PIX_WTH-1:0]  w_pix_nxt;

    // Which source FIFOs the latched mode consumes.
    assign w_need_conv = (r_mode == MD_PM) || (r_mode == MD_RM0) || (r_mode == MD_PM_RM1);
    assign w_need_part = (r_mode == MD_PM) || (r_mode == MD_PM_RM1);
    assign w_need_resd = (r_mode == MD_RM0) || (r_mode == MD_PM_RM1) || (r_mode == MD_RM_CONV);
    assign w_need_prev = (r_mode == MD_PV);
    assign w_need_dwc  = (r_mode == MD_RM_CONV) || (r_mode == MD_PV);
    assign w_pre_flow  = (r_mode == MD_PM) || (r_mode == MD_RM0) || (r_mode == MD_PM_RM1);

    assign w_srcs_rdy = !(w_need_conv && convMap_fifo_empty)
                     && !(w_need_part && partMap_fifo_empty)
                     && !(w_need_resd && resdMap_fifo_empty)
                     && !(w_need_prev && prevMap_fifo_empty)
                     && !(w_need_dwc  && conv1x1_dwc_fifo_empty);

    assign w_path_rdy  = sum_rdy && !FAS_rdy_n;
    assign w_pop_state = (r_state == ST_FILL) || (r_state == ST_POST);
    assign w_fire      = w_pop_state && w_srcs_rdy && w_path_rdy;
    assign w_adv       = w_fire || ((r_state == ST_REUSE) && w_path_rdy);

    assign w_krnl_nxt  = r_krnl + 1'b1;
    assign w_pix_nxt   = r_pix + 1'b1;
    assign w_pass_end  = w_adv && (r_dpth == r_dpth_end);
    assign w_pix_last  = (w_pix_nxt == r_num_pix);
    // FILL covers the first kernel pass; REUSE/POST count kernels via r_krnl.
    assign w_last_pass = (r_state == ST_FILL) ? (r_num_krnl == {{(KRNL_WTH-1){1'b0}}, 1'b1})
                                              : (w_krnl_nxt == r_num_krnl);
    assign w_start_ok  = (cfg_mode != MD_NONE) && (cfg_mode <= MD_PV) && (num_pix_cfg != '0);

    assign convMap_fifo_rd_en     = w_fire && w_need_conv;
    assign partMap_fifo_rd_en     = w_fire && w_need_part;
    assign resdMap_fifo_rd_en     = w_fire && w_need_resd;
    assign prevMap_fifo_rd_en     = w_fire && w_need_prev;
    assign conv1x1_dwc_fifo_rd_en = w_fire && w_need_dwc;

    assign vector_add_pm      = (r_state == ST_FILL) && ((r_mode == MD_PM) || (r_mode == MD_PM_RM1));
    assign vector_add_rm0     = (r_state == ST_FILL) && (r_mode == MD_RM0);
    assign vector_add_rm1     = (r_state == ST_FILL) && (r_mode == MD_PM_RM1);
    assign vector_add_rm_conv = (r_state == ST_POST) && (r_mode == MD_RM_CONV);
    assign vector_add_pv      = (r_state == ST_POST) && (r_mode == MD_PV);

    assign pipe_enable  = w_adv;
    assign busy         = (r_state != ST_IDLE);
    assign process_cmpl = (r_state == ST_DONE) && !FAS_rdy_n;
    assign cfg_err      = r_cfg_err;

    always_ff @(posedge clk_FAS) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mode     <= MD_NONE;
            r_dpth_end <= '0;
            r_num_krnl <= '0;
            r_num_pix  <= '0;
            r_dpth     <= '0;
            r_krnl     <= '0;
            r_pix      <= '0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_mode > MD_PV) begin
                            r_cfg_err <= 1'b1;
                        end else if (!w_start_ok) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_mode     <= cfg_mode;
                            r_dpth_end <= krnl1x1_dpth_end_cfg;
                            r_num_krnl <= (num_krnl1x1_cfg == '0) ? {{(KRNL_WTH-1){1'b0}}, 1'b1}
                                                                  : num_krnl1x1_cfg;
                            r_num_pix  <= num_pix_cfg;
                            r_dpth     <= '0;
                            r_krnl     <= '0;
                            r_pix      <= '0;
                            r_state    <= (cfg_mode <= MD_PM_RM1) ? ST_FILL : ST_POST;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    if (FAS_rdy_n) begin
                        r_state <= ST_IDLE;
                        r_dpth  <= '0;
                        r_krnl  <= '0;
                        r_pix   <= '0;
                    end else begin
                        if (w_adv) begin
                            r_dpth <= (r_dpth == r_dpth_end) ? '0 : r_dpth + 1'b1;
                        end
                        if (w_pass_end) begin
                            if (w_last_pass) begin
                                r_pix  <= w_pix_nxt;
                                r_krnl <= '0;
                                if (w_pix_last) begin
                                    r_state <= ST_DONE;
                                end else begin
                                    r_state <= w_pre_flow ? ST_FILL : ST_POST;
                                end
                            end else begin
                                r_krnl <= w_krnl_nxt;
                                if (r_state == ST_FILL) begin
                                    r_state <= ST_REUSE;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

`ifdef VEC_ADD_CTRL_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    // DONE is excluded so the count holds at its final value on completion.
    always_ff @(posedge clk_FAS) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if ((r_state == ST_IDLE) && start && (cfg_mode <= MD_PV)) begin
            r_stall_cycles <= '0;
        end else if ((w_pop_state || (r_state == ST_REUSE)) && !w_adv
                     && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_cnn_layer_accel_fas_vec_add_ctrl.sv
// Scoreboard bench for the FAS vector-add scheduler: expected beats are queued per run,
// a negedge monitor pops and compares them whenever pipe_enable is seen.
module tb_cnn_layer_accel_fas_vec_add_ctrl;

    localparam int DW = 16;
    localparam int KW = 16;
    localparam int PW = 20;
`ifdef VEC_ADD_CTRL_PERF_CNT_EN
    localparam int EXP_STALL = 3;
`else
    localparam int EXP_STALL = 0;
`endif

    logic          clk_FAS = 1'b0;
    logic          rst;
    logic          FAS_rdy_n;
    logic          start;
    logic [2:0]    cfg_mode;
    logic [DW-1:0] krnl1x1_dpth_end_cfg;
    logic [KW-1:0] num_krnl1x1_cfg;
    logic [PW-1:0] num_pix_cfg;
    logic          convMap_fifo_empty, partMap_fifo_empty, resdMap_fifo_empty;
    logic          prevMap_fifo_empty, conv1x1_dwc_fifo_empty, sum_rdy;
    logic          convMap_fifo_rd_en, partMap_fifo_rd_en, resdMap_fifo_rd_en;
    logic          prevMap_fifo_rd_en, conv1x1_dwc_fifo_rd_en;
    logic          vector_add_pm, vector_add_rm0, vector_add_rm1, vector_add_rm_conv, vector_add_pv;
    logic          pipe_enable, busy, process_cmpl, cfg_err;
    logic [31:0]   stall_cycles;

    always #5 clk_FAS = ~clk_FAS;

    cnn_layer_accel_fas_vec_add_ctrl #(.DPTH_WTH(DW), .KRNL_WTH(KW), .PIX_WTH(PW)) dut (
        .clk_FAS(clk_FAS), .rst(rst), .FAS_rdy_n(FAS_rdy_n), .start(start),
        .cfg_mode(cfg_mode), .krnl1x1_dpth_end_cfg(krnl1x1_dpth_end_cfg),
        .num_krnl1x1_cfg(num_krnl1x1_cfg), .num_pix_cfg(num_pix_cfg),
        .convMap_fifo_empty(convMap_fifo_empty), .partMap_fifo_empty(partMap_fifo_empty),
        .resdMap_fifo_empty(resdMap_fifo_empty), .prevMap_fifo_empty(prevMap_fifo_empty),
        .conv1x1_dwc_fifo_empty(conv1x1_dwc_fifo_empty), .sum_rdy(sum_rdy),
        .convMap_fifo_rd_en(convMap_fifo_rd_en), .partMap_fifo_rd_en(partMap_fifo_rd_en),
        .resdMap_fifo_rd_en(resdMap_fifo_rd_en), .prevMap_fifo_rd_en(prevMap_fifo_rd_en),
        .conv1x1_dwc_fifo_rd_en(conv1x1_dwc_fifo_rd_en),
        .vector_add_pm(vector_add_pm), .vector_add_rm0(vector_add_rm0),
        .vector_add_rm1(vector_add_rm1), .vector_add_rm_conv(vector_add_rm_conv),
        .vector_add_pv(vector_add_pv), .pipe_enable(pipe_enable), .busy(busy),
        .process_cmpl(process_cmpl), .cfg_err(cfg_err), .stall_cycles(stall_cycles)
    );

    // FIFO bit order: 0 conv, 1 part, 2 resd, 3 prev, 4 dwc.
    // Select bit order: 0 pm, 1 rm0, 2 rm1, 3 rm_conv, 4 pv.
    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] sel;
    } beat_t;

    beat_t beat_q[$];
    int    cmpl_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    int    g_emp_pct = 0;
    int    g_sum_pct = 100;
    int    g_toggle_part = 0;
    int    g_sum_low = 0;

    function automatic logic [4:0] req_mask(input int m);
        case (m)
            1: return 5'b00011;
            2: return 5'b00101;
            3: return 5'b00111;
            4: return 5'b10100;
            5: return 5'b11000;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic logic [4:0] sel_mask(input int m);
        case (m)
            1: return 5'b00001;
            2: return 5'b00010;
            3: return 5'b00101;
            4: return 5'b01000;
            5: return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic int kern_of(input int k);
        return (k == 0) ? 1 : k;
    endfunction

    // Reference: every pixel runs kern passes of (d+1) words; pre-1x1 flows pop only on pass 0.
    task automatic push_model(input int m, input int d, input int k, input int p);
        beat_t b;
        if (m > 5) return;
        cmpl_q.push_back(1);
        if (m == 0 || p == 0) return;
        for (int pi = 0; pi < p; pi++)
            for (int ki = 0; ki < kern_of(k); ki++)
                for (int di = 0; di <= d; di++) begin
                    if (m >= 4 || ki == 0) begin
                        b.rd  = req_mask(m);
                        b.sel = sel_mask(m);
                    end else begin
                        b.rd  = 5'b0;
                        b.sel = 5'b0;
                    end
                    beat_q.push_back(b);
                end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_FAS) begin
        logic [4:0] act_rd, act_sel, emp;
        beat_t      b;
        if (!rst) begin
            act_rd  = {conv1x1_dwc_fifo_rd_en, prevMap_fifo_rd_en, resdMap_fifo_rd_en,
                       partMap_fifo_rd_en, convMap_fifo_rd_en};
            act_sel = {vector_add_pv, vector_add_rm_conv, vector_add_rm1, vector_add_rm0, vector_add_pm};
            emp     = {conv1x1_dwc_fifo_empty, prevMap_fifo_empty, resdMap_fifo_empty,
                       partMap_fifo_empty, convMap_fifo_empty};
            if (pipe_enable) begin
                if (beat_q.size() == 0) begin
                    check("extra_beat", 32'd1, 32'd0);
                end else begin
                    b = beat_q.pop_front();
                    check("beat_rd_en", {27'd0, act_rd}, {27'd0, b.rd});
                    check("beat_select", {27'd0, act_sel}, {27'd0, b.sel});
                end
                check("pop_from_empty", {27'd0, act_rd & emp}, 32'd0);
                check("advance_needs_sum_rdy", {31'd0, sum_rdy}, 32'd1);
            end else begin
                check("rd_en_without_advance", {27'd0, act_rd}, 32'd0);
            end
            if (process_cmpl) begin
                if (cmpl_q.size() == 0) begin
                    check("unexpected_cmpl", 32'd1, 32'd0);
                end else begin
                    void'(cmpl_q.pop_front());
                    check("beats_left_at_cmpl", beat_q.size(), 32'd0);
                end
            end
        end
    end

    task automatic drive_cycle(input int n);
        convMap_fifo_empty     = ($urandom_range(99) < g_emp_pct);
        partMap_fifo_empty     = g_toggle_part ? (n % 2 == 1) : ($urandom_range(99) < g_emp_pct);
        resdMap_fifo_empty     = ($urandom_range(99) < g_emp_pct);
        prevMap_fifo_empty     = ($urandom_range(99) < g_emp_pct);
        conv1x1_dwc_fifo_empty = ($urandom_range(99) < g_emp_pct);
        sum_rdy = (n >= 1 && n <= g_sum_low) ? 1'b0 : ($urandom_range(99) < g_sum_pct);
    endtask

    // One run: returns cycle of process_cmpl (0 if none), number of advances, stall count at cmpl.
    task automatic run(input int m, input int d, input int k, input int p, input int abort_fire,
                       output int cmpl_cyc, output int fires, output int stall);
        bit abort_next = 0;
        bit done = 0;
        cmpl_cyc = 0;
        fires = 0;
        stall = 0;
        push_model(m, d, k, p);
        @(posedge clk_FAS); #1;
        cfg_mode = m[2:0];
        krnl1x1_dpth_end_cfg = DW'(d);
        num_krnl1x1_cfg = KW'(k);
        num_pix_cfg = PW'(p);
        start = 1'b1;
        drive_cycle(0);
        @(posedge clk_FAS); #1;
        start = 1'b0;
        drive_cycle(1);
        for (int n = 1; n <= 2000 && !done; n++) begin
            @(negedge clk_FAS);
            if (pipe_enable) fires++;
            if (process_cmpl) begin
                cmpl_cyc = n;
                stall = stall_cycles;
                done = 1;
            end else if (abort_fire > 0 && fires == abort_fire - 1) begin
                abort_next = 1;
                done = 1;
            end else if (n == 2000) begin
                check("run_timeout", 32'd1, 32'd0);
                beat_q.delete();
                cmpl_q.delete();
            end
            if (!done) begin
                @(posedge clk_FAS); #1;
                drive_cycle(n + 1);
            end
        end
        if (abort_next) begin
            @(posedge clk_FAS); #1;
            FAS_rdy_n = 1'b1;
            {convMap_fifo_empty, partMap_fifo_empty, resdMap_fifo_empty} = 3'b000;
            {prevMap_fifo_empty, conv1x1_dwc_fifo_empty} = 2'b00;
            sum_rdy = 1'b1;
            @(negedge clk_FAS);
            check("abort_cycle_no_advance", {31'd0, pipe_enable}, 32'd0);
            @(posedge clk_FAS); #1;
            FAS_rdy_n = 1'b0;
            @(negedge clk_FAS);
            check("abort_busy", {31'd0, busy}, 32'd0);
            check("abort_no_cmpl", {31'd0, process_cmpl}, 32'd0);
            beat_q.delete();
            cmpl_q.delete();
        end else if (cmpl_cyc > 0) begin
            @(posedge clk_FAS); #1;
            @(negedge clk_FAS);
            check("cmpl_one_cycle", {30'd0, busy, process_cmpl}, 32'd0);
        end
    endtask

    initial begin
        int c, f, s, m, d, k, p;
        rst = 1'b1;
        FAS_rdy_n = 1'b0;
        start = 1'b1;
        cfg_mode = 3'd1;
        krnl1x1_dpth_end_cfg = '0;
        num_krnl1x1_cfg = 1;
        num_pix_cfg = 1;
        {convMap_fifo_empty, partMap_fifo_empty, resdMap_fifo_empty} = 3'b000;
        {prevMap_fifo_empty, conv1x1_dwc_fifo_empty} = 2'b00;
        sum_rdy = 1'b1;
        repeat (3) @(posedge clk_FAS);
        @(negedge clk_FAS);
        check("reset_outputs",
              {17'd0, convMap_fifo_rd_en, partMap_fifo_rd_en, resdMap_fifo_rd_en, prevMap_fifo_rd_en,
               conv1x1_dwc_fifo_rd_en, vector_add_pm, vector_add_rm0, vector_add_rm1,
               vector_add_rm_conv, vector_add_pv, pipe_enable, busy, process_cmpl, cfg_err}, 32'd0);
        check("reset_stall", stall_cycles, 32'd0);
        @(posedge clk_FAS); #1;
        start = 1'b0;
        rst = 1'b0;

        run(1, 3, 2, 1, 0, c, f, s);
        check("m1_cmpl_cycle", c, 9);
        check("m1_advances", f, 8);

        run(4, 1, 3, 2, 0, c, f, s);
        check("m4_advances", f, 12);

        g_toggle_part = 1;
        run(3, 3, 2, 2, 0, c, f, s);
        check("m3_toggle_advances", f, 16);
        g_toggle_part = 0;

        run(2, 3, 2, 2, 3, c, f, s);
        run(2, 3, 2, 2, 0, c, f, s);
        check("m2_after_abort_advances", f, 16);
        check("m2_after_abort_cmpl", {31'd0, c > 0}, 32'd1);

        @(posedge clk_FAS); #1;
        cfg_mode = 3'd7;
        start = 1'b1;
        @(posedge clk_FAS); #1;
        start = 1'b0;
        @(negedge clk_FAS);
        check("illegal_cfg_err", {30'd0, cfg_err, busy}, 32'd2);
        @(negedge clk_FAS);
        check("illegal_cfg_err_pulse", {30'd0, cfg_err, busy}, 32'd0);

        run(0, 2, 2, 2, 0, c, f, s);
        check("m0_cmpl_prompt", {31'd0, c >= 1 && c <= 2}, 32'd1);
        check("m0_no_advance", f, 0);

        g_sum_low = 3;
        run(5, 0, 1, 4, 0, c, f, s);
        check("perf_advances", f, 4);
        check("perf_stall_cycles", s, EXP_STALL);
        g_sum_low = 0;

        for (int i = 0; i < 25; i++) begin
            m = $urandom_range(0, 5);
            d = $urandom_range(0, 3);
            k = $urandom_range(0, 3);
            p = $urandom_range(0, 4);
            g_emp_pct = $urandom_range(0, 40);
            g_sum_pct = $urandom_range(60, 100);
            run(m, d, k, p, 0, c, f, s);
            check("rand_advances", f, (m == 0) ? 0 : p * kern_of(k) * (d + 1));
            check("rand_cmpl_seen", {31'd0, c > 0}, 32'd1);
        end

        repeat (2) @(posedge clk_FAS);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
